// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state encoding and default sizing for freq_meter
package freq_meter_pkg;

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_MEASURE = 1'b1
    } fm_state_e;

    localparam int FM_W       = 16;
    localparam int FM_TIMEOUT = 1000;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer plus delay stage producing rise/fall strobes
module edge_sync (
    input  logic CLK_in,
    input  logic RST,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge CLK_in) begin
        if (RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - period / high-time meter with valid pulse, lock and sticky timeout
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int W           = FM_W,
    parameter int TIMEOUT_CYC = FM_TIMEOUT
) (
    input  logic         CLK_in,
    input  logic         RST,
    input  logic         SIG_in,
    output logic [W-1:0] PERIOD,
    output logic [W-1:0] HIGH_CNT,
    output logic         VALID,
    output logic         LOCKED,
    output logic         TIMEOUT
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W:0]   TO_VAL  = (W+1)'(TIMEOUT_CYC);

    logic rise, fall;

    edge_sync u_edge_sync (
        .CLK_in (CLK_in),
        .RST    (RST),
        .d      (SIG_in),
        .rise   (rise),
        .fall   (fall)
    );

    fm_state_e      state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   hi_tmp_q, hi_tmp_d;
    logic [W-1:0]   period_q, period_d;
    logic [W-1:0]   high_q, high_d;
    logic           valid_q, valid_d;
    logic           locked_q, locked_d;
    logic           timeout_q, timeout_d;

    logic [W:0]     cnt_inc;
    logic [W-1:0]   cnt_sat;
    logic           timeout_hit;

    // cnt+1 carries an extra bit so a saturated counter never wraps to zero
    assign cnt_inc     = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
    assign cnt_sat     = cnt_inc[W] ? CNT_MAX : cnt_inc[W-1:0];
    assign timeout_hit = (cnt_inc == TO_VAL);

    always_comb begin
        state_d   = state_q;
        hi_tmp_d  = hi_tmp_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (rise) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_inc[W-1:0];
        end

        case (state_q)
            ST_ACQUIRE: begin
                if (rise) begin
                    state_d   = ST_MEASURE;
                    timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    period_d  = cnt_sat;
                    high_d    = hi_tmp_q;
                    valid_d   = 1'b1;
                    locked_d  = (cnt_inc == {1'b0, period_q}) && (hi_tmp_q == high_q);
                    timeout_d = 1'b0;
                end else begin
                    if (fall) begin
                        hi_tmp_d = cnt_sat;
                    end
                    if (timeout_hit) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        state_d   = ST_ACQUIRE;
                    end
                end
            end
            default: begin
                state_d = ST_ACQUIRE;
            end
        endcase
    end

    always_ff @(posedge CLK_in) begin
        if (RST) begin
            state_q   <= ST_ACQUIRE;
            cnt_q     <= '0;
            hi_tmp_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_tmp_q  <= hi_tmp_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign PERIOD   = period_q;
    assign HIGH_CNT = high_q;
    assign VALID    = valid_q;
    assign LOCKED   = locked_q;
    assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter
module tb_freq_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sig, rst_to, sig_to;
    logic [15:0] period, high_cnt, period_to, high_to;
    logic        valid, locked, timeout, valid_to, locked_to, timeout_to;

    freq_meter dut (
        .CLK_in   (clk),
        .RST      (rst),
        .SIG_in   (sig),
        .PERIOD   (period),
        .HIGH_CNT (high_cnt),
        .VALID    (valid),
        .LOCKED   (locked),
        .TIMEOUT  (timeout)
    );

    freq_meter #(.TIMEOUT_CYC(50)) dut_to (
        .CLK_in   (clk),
        .RST      (rst_to),
        .SIG_in   (sig_to),
        .PERIOD   (period_to),
        .HIGH_CNT (high_to),
        .VALID    (valid_to),
        .LOCKED   (locked_to),
        .TIMEOUT  (timeout_to)
    );

    typedef struct {
        int p;
        int h;
        bit lk;
        int at;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic rst_s = 1'b1;
    logic lock_prev = 1'b0;

    int   mp, mh, pend_p, pend_h;
    bit   pend_ok;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    task check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one period of SIG_in starting with its rise; the rise completes the previous period
    task automatic drive_period(input int p, input int h, input int rst_at);
        exp_t e;
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            if (rst) begin
                check_val("mid_rst_outs", {period, high_cnt, valid, locked, timeout}, 40'd0);
                pend_ok = 0;
                mp = 0;
                mh = 0;
            end
            if (i == 0) begin
                if (pend_ok) begin
                    e.p  = pend_p;
                    e.h  = pend_h;
                    e.lk = (pend_p == mp) && (pend_h == mh);
                    e.at = cyc + 3;
                    sb.push_back(e);
                    mp = pend_p;
                    mh = pend_h;
                end
                pend_ok = 1;
                pend_p  = p;
                pend_h  = h;
            end
            sig = (i < h);
            rst = (rst_at != 0) && (i == rst_at - 1);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("valid_unexpected", 40'd1, 40'd0);
            end else begin
                e = sb.pop_front();
                check_val("sb_period", period, e.p);
                check_val("sb_high", high_cnt, e.h);
                check_val("sb_locked", locked, e.lk);
                check_val("sb_cycle", cyc, e.at);
            end
        end
        if (!rst_s && locked !== lock_prev && valid !== 1'b1 && timeout !== 1'b1)
            check_val("lock_no_valid", locked, lock_prev);
        lock_prev = locked;
    end

    initial begin
        int last_r, r;
        rst = 1'b1; sig = 1'b0; rst_to = 1'b1; sig_to = 1'b0;
        pend_ok = 0; mp = 0; mh = 0; pend_p = 0; pend_h = 0;

        @(negedge clk);
        sig = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("rst_outs", {period, high_cnt, valid, locked, timeout}, 40'd0);
            sig = ~sig;
        end
        rst = 1'b0;
        sig = 1'b0;
        repeat (3) @(negedge clk);

        repeat (10) drive_period(2, 1, 0);
        repeat (5)  drive_period(10, 5, 0);
        repeat (3)  drive_period(100, 50, 0);
        repeat (4)  drive_period(10, 3, 0);
        repeat (3)  drive_period(10, 4, 0);
        drive_period(100, 5, 7);
        repeat (2)  drive_period(100, 5, 0);

        @(negedge clk);
        rst_to = 1'b0;
        sig_to = 1'b0;
        repeat (2) @(negedge clk);
        last_r = 0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (i == 0) last_r = cyc + 1;
                sig_to = (i < 5);
            end
        end
        check_val("to_pre_locked", locked_to, 1'b1);
        check_val("to_pre_period", period_to, 16'd10);
        check_val("to_pre_high", high_to, 16'd5);

        while (cyc < last_r + 51) @(negedge clk);
        check_val("to_early", timeout_to, 1'b0);
        @(negedge clk);
        check_val("to_set", timeout_to, 1'b1);
        check_val("to_unlock", locked_to, 1'b0);
        check_val("to_period_kept", period_to, 16'd10);
        check_val("to_high_kept", high_to, 16'd5);

        r = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) begin
                r = cyc + 1;
            end else begin
                if (cyc == r + 1) check_val("to_hold", timeout_to, 1'b1);
                if (cyc == r + 2) check_val("to_clear", timeout_to, 1'b0);
                if (cyc == r + 11) check_val("to_valid_early", valid_to, 1'b0);
                if (cyc == r + 12) begin
                    check_val("to_valid", valid_to, 1'b1);
                    check_val("to_resume_period", period_to, 16'd10);
                    check_val("to_resume_locked", locked_to, 1'b1);
                end
            end
            sig_to = ((i % 10) < 5);
        end

        repeat (5) @(negedge clk);
        check_val("sb_empty", sb.size(), 40'd0);
        check_val("main_no_timeout", timeout, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the period and high time of a slow, periodic input signal in units of `CLK_in` cycles. It is the receiving end of the divided-clock outputs produced by `freq_div` (`CLK_50`, `CLK_10`, `CLK_1`). It is used on-chip to check that a divided clock runs at the expected ratio and duty cycle. Results are presented with a one-cycle valid pulse, a lock flag and a sticky timeout flag.

## Interface
Parameters:
- `W`, 16: counter and result width in bits.
- `TIMEOUT_CYC`, 1000: cycles without a rising edge before timeout; must be ≤ 2^W−1.

Ports:
- `CLK_in` input 1: sole clock.
- `RST` input 1: reset, synchronous and active-high.
- `SIG_in` input 1: signal under measurement; asynchronous to, or derived from, `CLK_in`.
- `PERIOD` output W: last measured rise-to-rise period, in cycles.
- `HIGH_CNT` output W: last measured high time (rise-to-fall), in cycles.
- `VALID` output 1: one-cycle pulse when `PERIOD`/`HIGH_CNT` are updated.
- `LOCKED` output 1: two consecutive measurements had identical `PERIOD` and `HIGH_CNT`.
- `TIMEOUT` output 1: sticky; no rising edge for `TIMEOUT_CYC` cycles.

## Operation
- **Input conditioning:** `SIG_in` passes through a 2-FF synchronizer (s1, s2) and a delay register s3.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
- **Counter `cnt` (W bits):**
  - Loads 0 on rise.
  - Otherwise increments each cycle.
  - Saturates at 2^W−1.
- **FSM state ACQUIRE** (reset state): waiting for the first rise.
  - On rise: go to MEASURE, load `cnt` = 0, clear `TIMEOUT`.
  - No `VALID` is produced in this state.
- **FSM state MEASURE:**
  - On fall: latch `hi_tmp` = `cnt` + 1.
  - On rise:
    - `PERIOD` ← `cnt` + 1.
    - `HIGH_CNT` ← `hi_tmp`.
    - `VALID` ← 1.
    - `LOCKED` ← 1 if (`cnt` + 1 == `PERIOD` && `hi_tmp` == `HIGH_CNT`), else 0.
    - This compares against the previous result registers.
  - If `cnt` + 1 == `TIMEOUT_CYC` and there is no rise this cycle:
    - `TIMEOUT` ← 1, `LOCKED` ← 0, go to ACQUIRE.
    - `PERIOD` and `HIGH_CNT` keep their old values.
- **Timeout in ACQUIRE:** the same timeout rule applies, so `TIMEOUT` also asserts if no first edge arrives. The state stays ACQUIRE.
- **Simultaneous events:**
  - Rise and timeout in the same cycle: the rise wins and no timeout is raised.
  - Rise and fall cannot coincide (single-bit input).
- **Constant-high input:** no fall is seen, so `hi_tmp` keeps its previous value. The timeout path still fires.
- **Arithmetic:** all comparisons are unsigned, W bits. `cnt` + 1 is computed in W+1 bits, so saturation never wraps.

## Timing
- **Reset values:**
  - Outputs: `PERIOD` = 0, `HIGH_CNT` = 0, `VALID` = 0, `LOCKED` = 0, `TIMEOUT` = 0.
  - Internal: state = ACQUIRE, `cnt` = 0, `hi_tmp` = 0, s1/s2/s3 = 0.
- **Latency:** a `SIG_in` transition sampled at edge n produces its rise/fall action at edge n+2. Results are visible after edge n+2.
- **Measurement results:** a periodic signal with period P and high time H gives `PERIOD` = P and `HIGH_CNT` = H exactly.
- **Output pulses:**
  - `VALID` is high for exactly one cycle per rising edge after the first.
  - `LOCKED` changes only in the same cycle `VALID` pulses, or on timeout.
- **Timeout timing:** `TIMEOUT` rises `TIMEOUT_CYC` cycles after the last rise action. It falls at the next rise action.
- **Reset mid-measurement:** `RST` sampled high at any edge returns everything to reset values at that edge. In-flight synchronizer contents are discarded.

## Structure
- **Package `freq_meter_pkg`:**
  - State enum (ACQUIRE, MEASURE).
  - Default constants `FM_W` = 16 and `FM_TIMEOUT` = 1000.
- **Sub-module `edge_sync`:**
  - Parameterless.
  - Ports `CLK_in`, `RST`, `d`, `rise`, `fall`.
  - Contains s1/s2/s3 and the edge logic.
- **Top:** FSM, counter, result registers and lock compare.

## Test plan
- **Reset values:** hold `RST` = 1 for 4 cycles with `SIG_in` toggling. All outputs must read 0 throughout, and no `VALID` may appear.
- **Divide-by-2 input:** drive `SIG_in` as a toggle on every `CLK_in` posedge.
  - Expect `PERIOD` = 2 and `HIGH_CNT` = 1.
  - The first `VALID` occurs 2 edges after the second rise is sampled.
  - `LOCKED` = 1 from the second `VALID`.
- **Divide-by-10 and divide-by-100 inputs (5/5 and 50/50 duty):** expect `PERIOD`/`HIGH_CNT` = 10/5, then 100/50. `VALID` spacing must equal the period.
- **Duty change:** change the input from 3 high/7 low to 4/6. The first `VALID` after the change shows `HIGH_CNT` = 4 with `LOCKED` = 0. The next `VALID` shows `LOCKED` = 1.
- **Timeout:** with `TIMEOUT_CYC` = 50, stop `SIG_in` low after lock.
  - `TIMEOUT` = 1 exactly 50 cycles after the last rise action.
  - At the same time `LOCKED` = 0 and `PERIOD` is unchanged.
  - On resuming a period-10 signal, `TIMEOUT` clears at the first rise. The first `VALID` occurs one period later.
- **Reset mid-measurement:** assert `RST` for 1 cycle at the 7th cycle of a period-100 measurement. All outputs return to 0. The next valid result is `PERIOD` = 100 after two further rises.
